// File: rtl/tone_pkg.sv
// Shared constants for the square-wave tone generator: note increments, envelope limits, FSM states.
package tone_pkg;

  localparam int          SAMPLE_RATE = 48000;
  localparam int          NUM_NOTES   = 10;
  localparam logic [7:0]  LEVEL_MAX   = 8'd255;
  localparam logic [15:0] AMP_UNIT    = 16'd39062;

  // round(f * 2^32 / SAMPLE_RATE) for C4 D4 E4 F4 G4 A4 B4 C5 D5 E5 at 48 kHz
  localparam logic [31:0] INC_TABLE [NUM_NOTES] = '{
    32'd23409859, 32'd26276679, 32'd29494575, 32'd31248413, 32'd35075158,
    32'd39370534, 32'd44191930, 32'd46819719, 32'd52553357, 32'd58989149
  };

  typedef enum logic [1:0] {
    S_CALC  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  function automatic logic [31:0] inc_lookup(input logic [3:0] idx);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (idx == 4'(i)) r = INC_TABLE[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/tone_sample_gen_env_ramp.sv
// Saturating +/-1 envelope level counter; bypass makes the level jump straight to its target.
module env_ramp
  import tone_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       gate,
  input  logic       step_en,
  input  logic       bypass,
  output logic [7:0] level,
  output logic [7:0] level_next
);

  logic [7:0] level_reg;

  always_comb begin
    level_next = level_reg;
    if (bypass) begin
      level_next = gate ? LEVEL_MAX : 8'd0;
    end else if (gate && level_reg != LEVEL_MAX) begin
      level_next = level_reg + 8'd1;
    end else if (!gate && level_reg != 8'd0) begin
      level_next = level_reg - 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      level_reg <= 8'd0;
    end else if (step_en) begin
      level_reg <= level_next;
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/tone_sample_gen.sv
// Square-wave tone sample generator feeding the audio output FIFO, one sample per handshake.
// Define TONE_ENVELOPE_EN for a linear attack/release envelope; otherwise level jumps to target.
module tone_sample_gen
  import tone_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  note_idx,
  input  logic        note_on,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        active
);

`ifdef TONE_ENVELOPE_EN
  localparam logic ENV_BYPASS = 1'b0;
`else
  localparam logic ENV_BYPASS = 1'b1;
`endif

  state_t      state_reg, state_next;
  logic [31:0] phase_reg;
  logic [31:0] inc_reg;
  logic [31:0] sample_reg;
  logic [7:0]  level;
  logic [7:0]  level_next;
  logic        gate;
  logic        step_en;
  logic [23:0] mag;
  logic [31:0] sample_next;

  assign gate    = note_on && (note_idx < 4'(NUM_NOTES));
  assign step_en = (state_reg == S_CALC);

  env_ramp u_env (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .gate       (gate),
    .step_en    (step_en),
    .bypass     (ENV_BYPASS),
    .level      (level),
    .level_next (level_next)
  );

  // Sample uses the level being written this S_CALC, signed by the current phase MSB
  assign mag         = {8'd0, AMP_UNIT} * {16'd0, level_next};
  assign sample_next = phase_reg[31] ? -{8'd0, mag} : {8'd0, mag};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_CALC:  state_next = S_WAIT;
      S_WAIT:  if (audio_out_allowed) state_next = S_WRITE;
      S_WRITE: state_next = S_CALC;
      default: state_next = S_CALC;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg  <= S_CALC;
      phase_reg  <= 32'd0;
      inc_reg    <= 32'd0;
      sample_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_CALC) begin
        if (gate) inc_reg <= inc_lookup(note_idx);
        sample_reg <= sample_next;
      end
      // Silence restarts the waveform at phase 0 so the next note begins on a positive half
      if (state_reg == S_WRITE) begin
        phase_reg <= (level == 8'd0) ? 32'd0 : phase_reg + inc_reg;
      end
    end
  end

  assign write_audio_out         = (state_reg == S_WRITE);
  assign left_channel_audio_out  = sample_reg;
  assign right_channel_audio_out = sample_reg;
  assign active                  = (level != 8'd0);

endmodule

// File: tb/tb_tone_sample_gen.sv
// Directed self-checking bench for tone_sample_gen; expectations follow the TONE_ENVELOPE_EN setting.
module tb_tone_sample_gen;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  note_idx = 4'd5;
  logic        note_on = 1'b0;
  logic        audio_out_allowed = 1'b1;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        active;

  int checks = 0;
  int errors = 0;
  int nwrites = 0;

  localparam logic [31:0] A4_INC = 32'd39370534;
  localparam int          AMP    = 39062;
  localparam int          FULL   = 9960810;
`ifdef TONE_ENVELOPE_EN
  localparam bit ENV = 1'b1;
`else
  localparam bit ENV = 1'b0;
`endif

  logic [31:0] m_phase;
  logic [31:0] m_inc;
  int          m_level;

  tone_sample_gen dut (
    .CLOCK_50                (CLOCK_50),
    .reset                   (reset),
    .note_idx                (note_idx),
    .note_on                 (note_on),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .active                  (active)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic model_reset();
    m_phase = 32'd0;
    m_inc   = 32'd0;
    m_level = 0;
  endtask

  // Expected sample for the next write, then advance the reference phase
  task automatic model_write(input bit g, input logic [31:0] inc, output logic [31:0] exp);
    logic [31:0] mag32;
    if (g) m_inc = inc;
    if (ENV) begin
      if (g && m_level < 255) m_level++;
      else if (!g && m_level > 0) m_level--;
    end else begin
      m_level = g ? 255 : 0;
    end
    mag32 = 32'(AMP * m_level);
    exp = m_phase[31] ? (~mag32 + 32'd1) : mag32;
    m_phase = (m_level == 0) ? 32'd0 : m_phase + m_inc;
  endtask

  task automatic check_write(input string name, input bit g, input logic [31:0] inc,
                             input int exp_gap, output logic [31:0] s);
    int gap;
    logic [31:0] exp;
    gap = 0;
    do begin
      @(negedge CLOCK_50);
      gap++;
    end while (!write_audio_out && gap < 1000);
    checks++;
    if (!write_audio_out) begin
      errors++;
      $display("FAIL %s strobe_timeout: no write within %0d cycles", name, gap);
    end
    s = left_channel_audio_out;
    model_write(g, inc, exp);
    nwrites++;
    $display("write %0d %s sample %0d level %0d gap %0d", nwrites, name, $signed(s), m_level, gap);
    checks++;
    if (s !== exp) begin
      errors++;
      $display("FAIL %s sample: got %0d expected %0d", name, $signed(s), $signed(exp));
    end
    checks++;
    if (right_channel_audio_out !== exp) begin
      errors++;
      $display("FAIL %s right: got %0d expected %0d", name, $signed(right_channel_audio_out), $signed(exp));
    end
    checks++;
    if (active !== (m_level != 0)) begin
      errors++;
      $display("FAIL %s active: got %0b expected %0b", name, active, (m_level != 0));
    end
    if (exp_gap > 0) begin
      checks++;
      if (gap != exp_gap) begin
        errors++;
        $display("FAIL %s cadence: got %0d cycles expected %0d", name, gap, exp_gap);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    reset = 1'b1; audio_out_allowed = 1'b1; note_on = 1'b1; note_idx = 4'd5;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLOCK_50);
      checks++;
      if (write_audio_out !== 1'b0 || left_channel_audio_out !== 32'd0 ||
          right_channel_audio_out !== 32'd0 || active !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: wr %0b l %0d r %0d act %0b expected all 0", write_audio_out,
                 left_channel_audio_out, right_channel_audio_out, active);
      end
    end
    reset = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    checks++;
    if (write_audio_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_early_strobe: got %0b expected 0", write_audio_out);
    end
    @(negedge CLOCK_50);
    checks++;
    if (write_audio_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_strobe: got %0b expected 1", write_audio_out);
    end
    model_write(1'b1, A4_INC, exp);
    nwrites++;
    $display("write %0d first sample %0d", nwrites, $signed(left_channel_audio_out));
    checks++;
    if (left_channel_audio_out !== (ENV ? 32'd39062 : 32'd9960810)) begin
      errors++;
      $display("FAIL reset_first_sample: got %0d expected %0d", $signed(left_channel_audio_out),
               ENV ? 39062 : FULL);
    end
  endtask

  task automatic test_attack();
    logic [31:0] s;
    for (int k = 1; k < 300; k++) begin
      check_write("attack", 1'b1, A4_INC, 3, s);
      if (k == 54) begin
        checks++;
        if (s[31] !== 1'b0) begin
          errors++;
          $display("FAIL attack_k54_sign: got %0d expected positive", $signed(s));
        end
      end
      if (k == 55) begin
        checks++;
        if (s !== -32'(ENV ? AMP * 56 : FULL)) begin
          errors++;
          $display("FAIL attack_k55_neg: got %0d expected %0d", $signed(s), -(ENV ? AMP * 56 : FULL));
        end
      end
      if (k >= 254) begin
        checks++;
        if (s !== 32'(FULL) && s !== -32'(FULL)) begin
          errors++;
          $display("FAIL attack_full_scale k %0d: got %0d expected +/-%0d", k, $signed(s), FULL);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s, held, exp;
    check_write("pre_stall", 1'b1, A4_INC, 3, s);
    audio_out_allowed = 1'b0;
    @(negedge CLOCK_50);
    held = left_channel_audio_out;
    for (int i = 0; i < 99; i++) begin
      @(negedge CLOCK_50);
      note_on = (i > 50) ? 1'b0 : 1'b1;
      checks++;
      if (write_audio_out !== 1'b0 || left_channel_audio_out !== held) begin
        errors++;
        $display("FAIL stall cycle %0d: wr %0b sample %0d expected 0 and %0d", i, write_audio_out,
                 $signed(left_channel_audio_out), $signed(held));
      end
    end
    note_on = 1'b1;
    audio_out_allowed = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (write_audio_out !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_strobe: got %0b expected 1", write_audio_out);
    end
    model_write(1'b1, A4_INC, exp);
    nwrites++;
    $display("write %0d post_stall sample %0d", nwrites, $signed(left_channel_audio_out));
    checks++;
    if (left_channel_audio_out !== exp) begin
      errors++;
      $display("FAIL stall_sample: got %0d expected %0d", $signed(left_channel_audio_out), $signed(exp));
    end
    for (int i = 0; i < 8; i++) check_write("post_stall", 1'b1, A4_INC, 3, s);
  endtask

  task automatic test_release();
    logic [31:0] s;
    note_on = 1'b0;
    check_write("release_first", 1'b0, A4_INC, 3, s);
    checks++;
    if (s !== 32'(ENV ? 9921748 : 0) && s !== -32'(ENV ? 9921748 : 0)) begin
      errors++;
      $display("FAIL release_first_mag: got %0d expected +/-%0d", $signed(s), ENV ? 9921748 : 0);
    end
    for (int i = 1; i < (ENV ? 255 : 1); i++) check_write("release", 1'b0, A4_INC, 3, s);
    for (int i = 0; i < 5; i++) begin
      check_write("silent", 1'b0, A4_INC, 3, s);
      checks++;
      if (s !== 32'd0 || active !== 1'b0) begin
        errors++;
        $display("FAIL silent: sample %0d active %0b expected 0 0", $signed(s), active);
      end
    end
    note_on = 1'b1;
    for (int i = 0; i < 70; i++) check_write("reattack", 1'b1, A4_INC, 3, s);
  endtask

  task automatic test_invalid();
    logic [31:0] s;
    @(negedge CLOCK_50);
    reset = 1'b1; note_idx = 4'd12; note_on = 1'b1; audio_out_allowed = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();
    check_write("invalid_first", 1'b0, 32'd0, 2, s);
    for (int i = 0; i < 12; i++) begin
      check_write("invalid", 1'b0, 32'd0, 3, s);
      checks++;
      if (s !== 32'd0 || active !== 1'b0) begin
        errors++;
        $display("FAIL invalid_note: sample %0d active %0b expected 0 0", $signed(s), active);
      end
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_backpressure();
    test_release();
    test_invalid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
